// File: rtl/lsu_req.sv
// rtl/lsu_req.sv - load/store request sequencer with byte-wise misaligned load support
module lsu_req (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_err,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  input  logic [31:0] load_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_BYTE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_result;
  logic [1:0]  r_cnt;
  logic        r_err;
  logic        r_misalign;

  logic        w_accept;
  logic        w_req_legal;
  logic        w_req_aligned;
  logic [3:0]  w_mask;
  logic        w_sign;
  logic [31:0] w_baddr;
  logic [1:0]  w_last;
  logic [31:0] w_assembled;
  logic [31:0] w_extended;

  // Request decode: legality and natural alignment of the incoming access
  always_comb begin
    w_accept      = req_valid && (r_state == S_IDLE);
    if (req_we)
      w_req_legal = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
    else
      w_req_legal = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110);
    case (req_funct3[1:0])
      2'b00:   w_req_aligned = 1'b1;
      2'b01:   w_req_aligned = (req_addr[0] == 1'b0);
      default: w_req_aligned = (req_addr[1:0] == 2'b00);
    endcase
  end

  // Registered-request datapath helpers: lane mask, sign flag, byte address, assembly
  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_mask = 4'b0001 << r_addr[1:0];
      2'b01:   w_mask = 4'b0011 << r_addr[1:0];
      default: w_mask = 4'b1111;
    endcase
    w_sign  = ~r_funct3[2] && (r_funct3[1:0] != 2'b10);
    w_baddr = r_addr + {30'd0, r_cnt};
    w_last  = (r_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
    w_assembled = r_result;
    case (r_cnt)
      2'd0:    w_assembled[7:0]   = load_data[7:0];
      2'd1:    w_assembled[15:8]  = load_data[7:0];
      2'd2:    w_assembled[23:16] = load_data[7:0];
      default: w_assembled[31:24] = load_data[7:0];
    endcase
    if (r_funct3[1:0] == 2'b01)
      w_extended = {{16{~r_funct3[2] & w_assembled[15]}}, w_assembled[15:0]};
    else
      w_extended = w_assembled;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and output decode; memory and response outputs are zero unless their state drives them
  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = 32'd0;
    resp_misalign = 1'b0;
    resp_err      = 1'b0;
    wmem          = 4'd0;
    rmem          = 5'd0;
    mem_addr      = 32'd0;
    store_data    = 32'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (!w_req_legal || (req_we && !w_req_aligned)) w_next = S_RESP;
          else if (w_req_aligned)                        w_next = S_ACCESS;
          else                                            w_next = S_BYTE;
        end
      end
      S_ACCESS: begin
        mem_addr = {2'b00, r_addr[31:2]};
        if (r_we) begin
          wmem       = w_mask;
          store_data = r_wdata;
        end else begin
          rmem = {w_sign, w_mask};
        end
        w_next = S_RESP;
      end
      S_BYTE: begin
        mem_addr = {2'b00, w_baddr[31:2]};
        rmem     = {1'b0, 4'b0001 << w_baddr[1:0]};
        if (r_cnt == w_last) w_next = S_RESP;
      end
      default: begin
        resp_valid    = 1'b1;
        resp_err      = r_err;
        resp_misalign = r_misalign & ~r_err;
        resp_rdata    = (!r_we && !r_err) ? r_result : 32'd0;
        w_next        = S_IDLE;
      end
    endcase
  end

  // Request capture on accept, load result capture in ACCESS, byte assembly in BYTE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_result   <= 32'd0;
      r_cnt      <= 2'd0;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_funct3   <= req_funct3;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
      r_result   <= 32'd0;
      r_cnt      <= 2'd0;
      r_err      <= ~w_req_legal;
      r_misalign <= w_req_legal & req_we & ~w_req_aligned;
    end else if (r_state == S_ACCESS) begin
      if (!r_we) r_result <= load_data;
    end else if (r_state == S_BYTE) begin
      r_cnt <= r_cnt + 2'd1;
      if (r_cnt == w_last) r_result <= w_extended;
      else                 r_result <= w_assembled;
    end
  end

endmodule

// File: tb/tb_lsu_req.sv
// tb/tb_lsu_req.sv - randomized and directed self-checking bench for lsu_req
module tb_lsu_req;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misalign, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr, store_data, load_data;

  int tests = 0;
  int fails = 0;

  logic [31:0] dmem [64];
  logic [7:0]  ref_mem [256];
  logic [72:0] t_q [$];
  logic [31:0] mw;

  lsu_req dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .resp_err(resp_err), .wmem(wmem), .rmem(rmem), .mem_addr(mem_addr),
    .store_data(store_data), .load_data(load_data)
  );

  always #5 clk = ~clk;

  // Memory: extracts and extends the selected lanes of the addressed word
  always_comb begin
    mw = dmem[mem_addr[5:0]];
    load_data = 32'd0;
    case (rmem[3:0])
      4'b0001: load_data = {{24{rmem[4] & mw[7]}},  mw[7:0]};
      4'b0010: load_data = {{24{rmem[4] & mw[15]}}, mw[15:8]};
      4'b0100: load_data = {{24{rmem[4] & mw[23]}}, mw[23:16]};
      4'b1000: load_data = {{24{rmem[4] & mw[31]}}, mw[31:24]};
      4'b0011: load_data = {{16{rmem[4] & mw[15]}}, mw[15:0]};
      4'b1100: load_data = {{16{rmem[4] & mw[31]}}, mw[31:16]};
      4'b1111: load_data = mw;
      default: load_data = 32'd0;
    endcase
  end

  function automatic logic [72:0] ent(input logic [31:0] a, input logic [4:0] r,
                                      input logic [3:0] w, input logic [31:0] s);
    return {a, r, w, s};
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    ref_mem[a] = v;
    dmem[a[7:2]][{a[1:0], 3'b000} +: 8] = v;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) poke(8'(i), 8'(i * 37 + 11));
  endtask

  // Reference: bytes read little-endian from the byte-addressed model, then extended by access type
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    logic [31:0] v;
    logic [7:0]  a;
    int n;
    n = 1 << f3[1:0];
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = addr[7:0] + 8'(k);
      v[8*k +: 8] = ref_mem[a];
    end
    if (n == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
    if (n == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Drives one request, holds garbage on req_valid while busy, records memory activity and the response
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                         output logic mis, output logic err, output int viol);
    int lo;
    t_q.delete();
    lat = -1; rd = 32'd0; mis = 1'b0; err = 1'b0; viol = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) viol++;
      if (wmem !== 4'd0 && rmem !== 5'd0) viol++;
      if (wmem !== 4'd0 || rmem !== 5'd0) begin
        t_q.push_back(ent(mem_addr, rmem, wmem, store_data));
        if (wmem !== 4'd0) begin
          lo = 0;
          for (int l = 3; l >= 0; l--) if (wmem[l]) lo = l;
          for (int l = 0; l < 4; l++)
            if (wmem[l]) dmem[mem_addr[5:0]][8*l +: 8] = store_data[8*(l-lo) +: 8];
        end
      end else if (mem_addr !== 32'd0 || store_data !== 32'd0) viol++;
      if (resp_valid === 1'b1) begin
        lat = c; rd = resp_rdata; mis = resp_misalign; err = resp_err;
        break;
      end else if (resp_rdata !== 32'd0 || resp_err !== 1'b0 || resp_misalign !== 1'b0) viol++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    tests++;
    if ({resp_valid, resp_rdata, resp_misalign, resp_err, wmem, rmem, mem_addr, store_data} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero (wmem %h rmem %h addr %h) expected all zero", wmem, rmem, mem_addr);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lw();
    int lat, viol; logic [31:0] rd; logic mis, err;
    poke(8'h10, 8'hEF); poke(8'h11, 8'hBE); poke(8'h12, 8'hAD); poke(8'h13, 8'hDE);
    run_req(1'b0, 3'b010, 32'h10, 32'd0, lat, rd, mis, err, viol);
    tests++; if (lat !== 2) begin fails++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
    tests++;
    if (t_q.size() != 1 || t_q[0] !== ent(32'h4, 5'b01111, 4'd0, 32'd0)) begin
      fails++; $display("FAIL lw_access: got %0d entries first %h expected 1 entry %h", t_q.size(),
                        (t_q.size() > 0) ? t_q[0] : 73'd0, ent(32'h4, 5'b01111, 4'd0, 32'd0));
    end
  endtask

  task automatic test_lb();
    int lat, viol; logic [31:0] rd; logic mis, err;
    poke(8'h06, 8'h80);
    run_req(1'b0, 3'b000, 32'h6, 32'd0, lat, rd, mis, err, viol);
    tests++; if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_rdata: got %h expected ffffff80", rd); end
    tests++;
    if (t_q.size() != 1 || t_q[0] !== ent(32'h1, 5'b10100, 4'd0, 32'd0)) begin
      fails++; $display("FAIL lb_rmem: got %0d entries expected rmem 10100 at word 1", t_q.size());
    end
    run_req(1'b0, 3'b100, 32'h6, 32'd0, lat, rd, mis, err, viol);
    tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu_rdata: got %h expected 00000080", rd); end
    tests++;
    if (t_q.size() != 1 || t_q[0] !== ent(32'h1, 5'b00100, 4'd0, 32'd0)) begin
      fails++; $display("FAIL lbu_rmem: got %0d entries expected rmem 00100 at word 1", t_q.size());
    end
  endtask

  task automatic test_sh();
    int lat, viol; logic [31:0] rd; logic mis, err;
    run_req(1'b1, 3'b001, 32'h2, 32'h1234ABCD, lat, rd, mis, err, viol);
    ref_mem[2] = 8'hCD; ref_mem[3] = 8'hAB;
    tests++;
    if (lat !== 2 || mis !== 1'b0 || rd !== 32'd0) begin
      fails++; $display("FAIL sh_resp: got lat %0d mis %b rd %h expected 2 0 0", lat, mis, rd);
    end
    tests++;
    if (t_q.size() != 1 || t_q[0] !== ent(32'h0, 5'd0, 4'b1100, 32'h1234ABCD)) begin
      fails++; $display("FAIL sh_write: got %0d entries first %h expected wmem 1100 data 1234abcd", t_q.size(),
                        (t_q.size() > 0) ? t_q[0] : 73'd0);
    end
    run_req(1'b0, 3'b101, 32'h2, 32'd0, lat, rd, mis, err, viol);
    tests++; if (rd !== 32'h0000ABCD) begin fails++; $display("FAIL sh_readback: got %h expected 0000abcd", rd); end
  endtask

  task automatic test_lh_misaligned();
    int lat, viol; logic [31:0] rd; logic mis, err;
    logic [7:0]  b0 [2];
    logic [7:0]  b1 [2];
    logic [31:0] e_lh [2];
    logic [31:0] e_lhu [2];
    b0[0] = 8'h80; b1[0] = 8'h01; e_lh[0] = 32'h00000180; e_lhu[0] = 32'h00000180;
    b0[1] = 8'h01; b1[1] = 8'h80; e_lh[1] = 32'hFFFF8001; e_lhu[1] = 32'h00008001;
    for (int i = 0; i < 2; i++) begin
      poke(8'h03, b0[i]); poke(8'h04, b1[i]);
      run_req(1'b0, 3'b001, 32'h3, 32'd0, lat, rd, mis, err, viol);
      tests++; if (lat !== 3) begin fails++; $display("FAIL lh_mis_latency: got %0d expected 3", lat); end
      tests++; if (rd !== e_lh[i]) begin fails++; $display("FAIL lh_mis_rdata: got %h expected %h", rd, e_lh[i]); end
      tests++;
      if (t_q.size() != 2 || t_q[0] !== ent(32'h0, 5'b01000, 4'd0, 32'd0) ||
          t_q[1] !== ent(32'h1, 5'b00001, 4'd0, 32'd0)) begin
        fails++; $display("FAIL lh_mis_bytes: got %0d entries expected word0/01000 then word1/00001", t_q.size());
      end
      run_req(1'b0, 3'b101, 32'h3, 32'd0, lat, rd, mis, err, viol);
      tests++; if (rd !== e_lhu[i]) begin fails++; $display("FAIL lhu_mis_rdata: got %h expected %h", rd, e_lhu[i]); end
    end
  endtask

  task automatic test_sw_misalign_err();
    int lat, viol; logic [31:0] rd; logic mis, err;
    run_req(1'b1, 3'b010, 32'h5, 32'hCAFEF00D, lat, rd, mis, err, viol);
    tests++;
    if (lat !== 1 || mis !== 1'b1 || err !== 1'b0 || t_q.size() != 0 || viol != 0) begin
      fails++; $display("FAIL sw_misalign: got lat %0d mis %b err %b acc %0d viol %0d expected 1 1 0 0 0",
                        lat, mis, err, t_q.size(), viol);
    end
    run_req(1'b0, 3'b011, 32'h8, 32'd0, lat, rd, mis, err, viol);
    tests++;
    if (lat !== 1 || err !== 1'b1 || mis !== 1'b0 || rd !== 32'd0 || t_q.size() != 0) begin
      fails++; $display("FAIL illegal_load: got lat %0d err %b mis %b rd %h acc %0d expected 1 1 0 0 0",
                        lat, err, mis, rd, t_q.size());
    end
    run_req(1'b1, 3'b011, 32'h5, 32'd0, lat, rd, mis, err, viol);
    tests++;
    if (err !== 1'b1 || mis !== 1'b0 || t_q.size() != 0) begin
      fails++; $display("FAIL err_priority: got err %b mis %b expected 1 0", err, mis);
    end
  endtask

  task automatic test_reset_abort();
    int lat, viol, seen; logic [31:0] rd; logic mis, err;
    poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33); poke(8'h01, 8'h44);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'hFFFFFFFE; req_wdata = 32'd0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    tests++;
    if (mem_addr !== 32'd0 || rmem !== 5'b00001) begin
      fails++; $display("FAIL wrap_byte2: got addr %h rmem %b expected 0 00001", mem_addr, rmem);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({resp_valid, resp_rdata, resp_misalign, resp_err, wmem, rmem, mem_addr, store_data} !== '0 ||
        req_ready !== 1'b1) begin
      fails++; $display("FAIL abort_outputs: got ready %b rmem %b addr %h expected 1 0 0", req_ready, rmem, mem_addr);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (resp_valid === 1'b1) seen++; end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_no_resp: got %0d responses expected 0", seen); end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    tests++; if (wmem !== 4'b1111) begin fails++; $display("FAIL store_access: got wmem %b expected 1111", wmem); end
    rst = 1'b1;
    #1;
    tests++; if (wmem !== 4'd0) begin fails++; $display("FAIL store_abort: got wmem %b expected 0000", wmem); end
    @(negedge clk); rst = 1'b0;
    run_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, lat, rd, mis, err, viol);
    tests++;
    if (lat !== 5 || rd !== 32'h44332211) begin
      fails++; $display("FAIL after_abort: got lat %0d rd %h expected 5 44332211", lat, rd);
    end
    tests++;
    if (t_q.size() != 4 || t_q[0] !== ent(32'h3FFFFFFF, 5'b00100, 4'd0, 32'd0) ||
        t_q[1] !== ent(32'h3FFFFFFF, 5'b01000, 4'd0, 32'd0) ||
        t_q[2] !== ent(32'h0, 5'b00001, 4'd0, 32'd0) || t_q[3] !== ent(32'h0, 5'b00010, 4'd0, 32'd0)) begin
      fails++; $display("FAIL wrap_sequence: got %0d entries expected 4 with wrap to word 0", t_q.size());
    end
  endtask

  task automatic test_random();
    int lat, viol, n, e_lat; logic [31:0] rd, e_rd, addr, wdata; logic mis, err, e_mis, e_err, we;
    logic [2:0] f3; logic legal, aligned; logic [3:0] mask; logic [31:0] ba; logic [72:0] e_q [$];
    init_mem();
    for (int it = 0; it < 300; it++) begin
      we = 1'($urandom); f3 = 3'($urandom_range(0, 7)); wdata = $urandom;
      addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
      n = (f3[1:0] == 2'b11) ? 0 : (1 << f3[1:0]);
      legal = we ? (n != 0 && !f3[2]) : (n != 0 && f3 != 3'b110);
      aligned = (n != 0) && (addr % n == 0);
      e_q.delete(); e_rd = 32'd0; e_mis = 1'b0; e_err = 1'b0;
      if (!legal) begin e_lat = 1; e_err = 1'b1; end
      else if (we && !aligned) begin e_lat = 1; e_mis = 1'b1; end
      else if (aligned) begin
        e_lat = 2;
        mask = 4'(((1 << n) - 1) << (addr % 4));
        if (we) e_q.push_back(ent(addr >> 2, 5'd0, mask, wdata));
        else begin
          e_q.push_back(ent(addr >> 2, {(!f3[2] && n != 4), mask}, 4'd0, 32'd0));
          e_rd = ref_load(addr, f3);
        end
      end else begin
        e_lat = n + 1;
        for (int k = 0; k < n; k++) begin
          ba = addr + 32'(k);
          e_q.push_back(ent(ba >> 2, {1'b0, 4'(1 << (ba % 4))}, 4'd0, 32'd0));
        end
        e_rd = ref_load(addr, f3);
      end
      run_req(we, f3, addr, wdata, lat, rd, mis, err, viol);
      if (legal && we && aligned)
        for (int k = 0; k < n; k++) ref_mem[8'(addr[7:0] + 8'(k))] = wdata[8*k +: 8];
      tests++;
      if (lat !== e_lat || rd !== e_rd || mis !== e_mis || err !== e_err) begin
        fails++; $display("FAIL rand_resp we=%b f3=%b addr=%h: got lat %0d rd %h mis %b err %b expected %0d %h %b %b",
                          we, f3, addr, lat, rd, mis, err, e_lat, e_rd, e_mis, e_err);
      end
      tests++;
      if (viol != 0) begin fails++; $display("FAIL rand_invariants addr=%h: got %0d violations expected 0", addr, viol); end
      tests++;
      if (t_q.size() != e_q.size()) begin
        fails++; $display("FAIL rand_access_count addr=%h f3=%b: got %0d expected %0d", addr, f3, t_q.size(), e_q.size());
      end else begin
        for (int k = 0; k < e_q.size(); k++)
          if (t_q[k] !== e_q[k]) begin
            fails++; $display("FAIL rand_access addr=%h f3=%b #%0d: got %h expected %h", addr, f3, k, t_q[k], e_q[k]);
            break;
          end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) dmem[i] = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_lh_misaligned();
    test_sw_misalign_err();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
